// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage
//
// Fetch stage sitting after the program counter. Reads the word at the
// incoming word address from a small internal instruction memory and captures
// it, together with its address, into the IF/ID register under a valid/ready
// handshake toward decode. pc_scr tells the program counter whether to advance
// (all zeros) or hold (all ones). The PC advances only on edges where a word
// is captured, so no address is ever skipped or fetched twice.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   pc_in        word address from the program counter
//   load_en      program-load write strobe (blocks capture, holds PC)
//   load_addr    program-load word index
//   load_data    program-load word
//   flush        discard IF/ID contents this cycle
//   id_ready     decode accepts IF/ID this cycle
//   if_id_valid  IF/ID holds a valid instruction
//   if_id_ins    registered instruction
//   if_id_pc     registered address of if_id_ins
//   halted       stage has fetched a halt instruction and stopped
//   pc_scr       PC control: 7'b0000000 advance, 7'b1111111 hold
//   fetch_count  instructions captured since reset (wraps)

module instruction_fetch_stage #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned ADDR_BITS   = 8,
  parameter logic [6:0]  HALT_OPCODE = 7'b1111111
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     pc_in,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [WIDTH-1:0]     load_data,
  input  logic                 flush,
  input  logic                 id_ready,
  output logic                 if_id_valid,
  output logic [WIDTH-1:0]     if_id_ins,
  output logic [WIDTH-1:0]     if_id_pc,
  output logic                 halted,
  output logic [6:0]           pc_scr,
  output logic [WIDTH-1:0]     fetch_count
);

  localparam int unsigned    Depth   = 2 ** ADDR_BITS;
  localparam logic [WIDTH-1:0] NopIns = WIDTH'(32'h0000_0013);
  localparam logic [6:0]     ScrHold = 7'b1111111;
  localparam logic [6:0]     ScrAdv  = 7'b0000000;

  typedef enum logic [0:0] {
    StRun,
    StHalted
  } state_e;

  state_e state_q, state_d;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] ins_q, ins_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] count_q, count_d;

  // ---------------------------------------------------------------------------
  // Instruction memory: written only by the program loader, never cleared.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  // Addresses beyond the memory read back as a NOP rather than aliasing.
  logic             in_range;
  logic [WIDTH-1:0] fetch_word;

  always_comb begin
    in_range   = (pc_in >> ADDR_BITS) == '0;
    fetch_word = in_range ? mem[pc_in[ADDR_BITS-1:0]] : NopIns;
  end

  // ---------------------------------------------------------------------------
  // Capture condition and PC control.
  // rst is included so pc_scr reads "hold" while reset is asserted, even though
  // the registers are already being forced by the asynchronous clear.
  // ---------------------------------------------------------------------------
  logic cap;
  logic is_halt_word;

  always_comb begin
    cap          = (state_q == StRun) && rst && !load_en && !flush &&
                   (!valid_q || id_ready);
    is_halt_word = fetch_word[6:0] == HALT_OPCODE;
    pc_scr       = cap ? ScrAdv : ScrHold;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Flush wins over capture (cap is already low when flush is
  // set) and over consumption, so flush together with id_ready leaves IF/ID
  // empty. IF/ID data is only rewritten on capture; a stall or flush leaves it.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    ins_d   = ins_q;
    pc_d    = pc_q;
    count_d = count_q;

    if (flush) begin
      valid_d = 1'b0;
    end else if (cap) begin
      valid_d = 1'b1;
      ins_d   = fetch_word;
      pc_d    = pc_in;
      count_d = count_q + WIDTH'(1);
      if (is_halt_word) begin
        state_d = StHalted;
      end
    end else if (valid_q && id_ready) begin
      valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StRun;
      valid_q <= 1'b0;
      ins_q   <= '0;
      pc_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ins_q   <= ins_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    if_id_valid = valid_q;
    if_id_ins   = ins_q;
    if_id_pc    = pc_q;
    fetch_count = count_q;
    halted      = (state_q == StHalted);
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage. The bench plays the program counter: it
// holds pc_in and bumps it after any edge where pc_scr read "advance". A small
// reference model plus a queue of expected {instruction, address} pairs checks
// every word handed to decode; a vector table pins down the main sequence.

module tb_instruction_fetch_stage;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic        flush;
  logic        id_ready;
  logic        if_id_valid;
  logic [31:0] if_id_ins;
  logic [31:0] if_id_pc;
  logic        halted;
  logic [6:0]  pc_scr;
  logic [31:0] fetch_count;

  instruction_fetch_stage #(
    .WIDTH      (32),
    .ADDR_BITS  (8),
    .HALT_OPCODE(7'b1111111)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .flush      (flush),
    .id_ready   (id_ready),
    .if_id_valid(if_id_valid),
    .if_id_ins  (if_id_ins),
    .if_id_pc   (if_id_pc),
    .halted     (halted),
    .pc_scr     (pc_scr),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model state.
  logic [31:0] mem_m [256];
  logic        m_valid;
  logic        m_halted;
  logic [31:0] m_count;
  logic [63:0] exp_q [$];

  task automatic model_reset();
    m_valid  = 1'b0;
    m_halted = 1'b0;
    m_count  = 32'd0;
    exp_q.delete();
  endtask

  // One clock: inputs already driven. Checks pc_scr and any word consumed by
  // decode before the edge, then the registered state after it.
  task automatic cycle(output logic [6:0] scr_seen);
    logic        mcap;
    logic [31:0] fw;
    logic [63:0] ent;
    logic        adv;
    #1;
    fw   = (pc_in[31:8] == 24'd0) ? mem_m[pc_in[7:0]] : 32'h0000_0013;
    mcap = !m_halted && rst && !load_en && !flush && (!m_valid || id_ready);
    scr_seen = pc_scr;
    chk("pc_scr", {25'd0, pc_scr}, mcap ? 32'd0 : 32'h7f);
    if (m_valid && (id_ready || flush)) begin
      if (exp_q.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        ent = exp_q.pop_front();
        if (id_ready && !flush) begin
          chk("sb_ins", if_id_ins, ent[63:32]);
          chk("sb_pc", if_id_pc, ent[31:0]);
        end
      end
    end
    if (mcap) exp_q.push_back({fw, pc_in});
    adv = (pc_scr == 7'd0);
    @(posedge clk);
    #1;
    if (adv) pc_in = pc_in + 32'd1;
    if (load_en) mem_m[load_addr] = load_data;
    if (flush) m_valid = 1'b0;
    else if (mcap) m_valid = 1'b1;
    else if (m_valid && id_ready) m_valid = 1'b0;
    if (mcap) begin
      m_count = m_count + 32'd1;
      if (fw[6:0] == 7'h7f) m_halted = 1'b1;
    end
    chk("valid", {31'd0, if_id_valid}, {31'd0, m_valid});
    chk("halted", {31'd0, halted}, {31'd0, m_halted});
    chk("count", fetch_count, m_count);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_valid"}, {31'd0, if_id_valid}, 32'd0);
    chk({tag, "_ins"}, if_id_ins, 32'd0);
    chk({tag, "_pc"}, if_id_pc, 32'd0);
    chk({tag, "_count"}, fetch_count, 32'd0);
    chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
    chk({tag, "_scr"}, {25'd0, pc_scr}, 32'h7f);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear at once.
  task automatic reset_pulse(input string tag);
    rst = 1'b0;
    #2;
    check_reset_vals(tag);
    model_reset();
    pc_in = 32'd0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic load_word(input logic [7:0] a, input logic [31:0] d);
    logic [6:0] s;
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    cycle(s);
    load_en   = 1'b0;
  endtask

  typedef struct {
    logic        rdy;
    logic        fl;
    logic [6:0]  scr;
    logic        vld;
    logic [31:0] ins;
    logic [31:0] ipc;
    logic [31:0] pcn;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [6:0] s;

    tbl[0]  = '{1'b1, 1'b0, 7'h00, 1'b1, 32'h11, 32'd0, 32'd1, 32'd1};
    tbl[1]  = '{1'b1, 1'b0, 7'h00, 1'b1, 32'h22, 32'd1, 32'd2, 32'd2};
    tbl[2]  = '{1'b0, 1'b0, 7'h7f, 1'b1, 32'h22, 32'd1, 32'd2, 32'd2};
    tbl[3]  = '{1'b0, 1'b0, 7'h7f, 1'b1, 32'h22, 32'd1, 32'd2, 32'd2};
    tbl[4]  = '{1'b0, 1'b0, 7'h7f, 1'b1, 32'h22, 32'd1, 32'd2, 32'd2};
    tbl[5]  = '{1'b1, 1'b0, 7'h00, 1'b1, 32'h33, 32'd2, 32'd3, 32'd3};
    tbl[6]  = '{1'b1, 1'b0, 7'h00, 1'b1, 32'h44, 32'd3, 32'd4, 32'd4};
    tbl[7]  = '{1'b0, 1'b1, 7'h7f, 1'b0, 32'h0,  32'd0, 32'd4, 32'd4};
    tbl[8]  = '{1'b0, 1'b0, 7'h00, 1'b1, 32'h55, 32'd4, 32'd5, 32'd5};
    tbl[9]  = '{1'b1, 1'b1, 7'h7f, 1'b0, 32'h0,  32'd0, 32'd5, 32'd5};
    tbl[10] = '{1'b1, 1'b0, 7'h00, 1'b1, 32'h66, 32'd5, 32'd6, 32'd6};

    rst       = 1'b0;
    pc_in     = 32'd0;
    load_en   = 1'b0;
    load_addr = 8'd0;
    load_data = 32'd0;
    flush     = 1'b0;
    id_ready  = 1'b0;
    model_reset();
    #2;
    check_reset_vals("rst0");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Program load: PC held, nothing captured.
    load_word(8'd0, 32'h11);
    load_word(8'd1, 32'h22);
    load_word(8'd2, 32'h33);
    load_word(8'd3, 32'h44);
    load_word(8'd4, 32'h55);
    load_word(8'd5, 32'h66);
    chk("load_pc_held", pc_in, 32'd0);

    // Main sequence: streaming, stall, flush, flush with ready.
    for (int i = 0; i < 11; i++) begin
      id_ready = tbl[i].rdy;
      flush    = tbl[i].fl;
      cycle(s);
      chk($sformatf("v%0d_scr", i), {25'd0, s}, {25'd0, tbl[i].scr});
      chk($sformatf("v%0d_valid", i), {31'd0, if_id_valid}, {31'd0, tbl[i].vld});
      if (tbl[i].vld) begin
        chk($sformatf("v%0d_ins", i), if_id_ins, tbl[i].ins);
        chk($sformatf("v%0d_ipc", i), if_id_pc, tbl[i].ipc);
      end
      chk($sformatf("v%0d_pcin", i), pc_in, tbl[i].pcn);
      chk($sformatf("v%0d_cnt", i), fetch_count, tbl[i].cnt);
    end
    flush = 1'b0;

    // Load while IF/ID is valid and decode is ready: consumed, no capture.
    id_ready  = 1'b1;
    load_word(8'd6, 32'h77);
    chk("load_consume", {31'd0, if_id_valid}, 32'd0);
    chk("load_pc", pc_in, 32'd6);
    cycle(s);
    chk("after_load_ins", if_id_ins, 32'h77);

    // Out-of-range address reads as NOP.
    pc_in = 32'h100;
    cycle(s);
    chk("nop_ins", if_id_ins, 32'h0000_0013);
    chk("nop_pc", if_id_pc, 32'h100);
    cycle(s);

    // Halt: plant the halt word, restart from 0 via a mid-stream reset.
    id_ready = 1'b0;
    load_word(8'd2, 32'h0000_007f);
    reset_pulse("rst1");
    id_ready = 1'b1;
    repeat (3) cycle(s);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_ins", if_id_ins, 32'h7f);
    chk("halt_pc", pc_in, 32'd3);
    chk("halt_cnt", fetch_count, 32'd3);
    repeat (3) cycle(s);
    flush = 1'b1;
    cycle(s);
    flush = 1'b0;
    repeat (2) cycle(s);
    chk("halt_stay", {31'd0, halted}, 32'd1);
    chk("halt_pc_frozen", pc_in, 32'd3);
    chk("halt_cnt_frozen", fetch_count, 32'd3);
    chk("halt_scr", {25'd0, pc_scr}, 32'h7f);

    // Reset while halted clears it and fetch restarts at address 0.
    reset_pulse("rst2");
    cycle(s);
    chk("restart_ins", if_id_ins, 32'h11);
    chk("restart_pc", if_id_pc, 32'd0);
    chk("restart_pcin", pc_in, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Fetch stage downstream of `program_counter`. It takes the word address `current_ins_add` and reads the instruction from an internal word-addressed instruction memory. The word is captured with its address into the IF/ID pipeline register under a valid/ready handshake toward decode. The stage drives `pc_scr` back to the PC: `7'b1111111` freezes the PC on stall, flush, program load or halt.

## Interface
- `WIDTH`, 32: instruction and address width.
- `ADDR_BITS`, 8: memory index bits; depth = 2^ADDR_BITS words.
- `HALT_OPCODE`, 7'b1111111: opcode (`ins[6:0]`) that halts fetch.
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `pc_in`  in  WIDTH: word address from `program_counter.current_ins_add`.
- `load_en`  in  1: program-load write strobe.
- `load_addr`  in  ADDR_BITS: program-load word index.
- `load_data`  in  WIDTH: program-load word.
- `flush`  in  1: discard IF/ID contents.
- `id_ready`  in  1: decode accepts IF/ID this cycle.
- `if_id_valid`  out  1: IF/ID holds a valid instruction.
- `if_id_ins`  out  WIDTH: registered instruction.
- `if_id_pc`  out  WIDTH: registered address of `if_id_ins`.
- `halted`  out  1: stage is in HALTED.
- `pc_scr`  out  7: PC control; `7'b1111111` = hold, `7'b0000000` = advance.
- `fetch_count`  out  WIDTH: number of instructions captured since reset.

## Operation
- Memory
  - `mem[2^ADDR_BITS]` of WIDTH bits.
  - Written only at a clock edge when `load_en`=1: `mem[load_addr] <= load_data`.
  - Not cleared by reset.
- Fetch word, combinational:
  - `mem[pc_in[ADDR_BITS-1:0]]` when `pc_in[WIDTH-1:ADDR_BITS]` is 0.
  - Otherwise NOP `32'h0000_0013`.
- FSM has two states, reset state RUN.
  - RUN -> HALTED on a capture whose fetch word has `[6:0]==HALT_OPCODE`.
  - HALTED -> RUN only by reset. `flush` does not leave HALTED.
- `cap` = RUN && `rst` && !`load_en` && !`flush` && (!`if_id_valid` || `id_ready`).
- On `cap`:
  - `if_id_ins <= fetch word`, `if_id_pc <= pc_in`, `if_id_valid <= 1`.
  - `fetch_count` increments, wrapping modulo 2^WIDTH.
- On `flush`: `if_id_valid <= 0`, no capture. Flush overrides capture and halt detection in the same cycle.
- No `cap`, no `flush`, and `if_id_valid && id_ready`: `if_id_valid <= 0` (consumed).
- Stall (`if_id_valid && !id_ready`): IF/ID contents held unchanged.
- `pc_scr`, combinational:
  - `7'b0000000` exactly when `cap`=1.
  - `7'b1111111` otherwise, including while `rst`=0.
  - The PC therefore advances exactly on the edges where a word is captured, so no address is skipped or duplicated.
- `halted` = (state == HALTED).

## Timing
- Reset (async assert, `rst`=0): `if_id_valid`=0, `if_id_ins`=0, `if_id_pc`=0, `fetch_count`=0, `halted`=0, `pc_scr`=7'b1111111. Reset takes effect immediately, mid-operation included.
- Latency: the word at address A appears in IF/ID one edge after `pc_in`=A with `cap`=1. In the same edge the PC moves to A+1.
- Throughput: one instruction per cycle while `id_ready`=1.
- Halt:
  - At the edge capturing a HALT_OPCODE word at A: IF/ID receives it (valid), the PC moves to A+1, and `halted` rises.
  - Afterwards `pc_scr` is held at 7'b1111111, `fetch_count` is frozen, and the halt word is consumed normally by `id_ready`.
- Flush: IF/ID is empty after one edge and the PC is held that cycle. The word at the current `pc_in` is fetched on the next cycle.
- Load: every cycle with `load_en`=1 holds the PC and blocks capture. IF/ID keeps its contents but can still be consumed.
- Simultaneous flush + `id_ready`: the result is empty.

## Test plan
- Reset release with `mem[0..3]` = 0x11,0x22,0x33,0x44 and `id_ready`=1 -> `if_id_ins` = 0x11,0x22,0x33,0x44 on consecutive cycles, `if_id_pc` = 0..3, `fetch_count`=4, `pc_scr`=0 every cycle.
- `id_ready`=0 for 3 cycles while holding 0x22 -> `if_id_ins`=0x22 held, `pc_scr`=7'b1111111, PC frozen at 2; resume yields 0x33 next with no skip.
- `mem[2]`=0x0000007F -> `halted`=1 after the edge capturing address 2, PC stays at 3, `fetch_count`=3 thereafter, `pc_scr`=7'b1111111 indefinitely.
- `flush`=1 while IF/ID holds address 1 -> `if_id_valid`=0 next cycle, PC held one cycle, then address 2 captured.
- `pc_in`=0x100 with ADDR_BITS=8 -> `if_id_ins`=0x00000013.
- `rst` pulsed low mid-stream (between edges) -> all outputs take reset values immediately, `halted` clears, and fetch restarts from address 0 after release.
